// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG word arbiter and its word FIFO.
package trng_pkg;

  localparam int TRNG_WORD_W = 32;

  localparam int PORT_UART = 0;
  localparam int PORT_CPU  = 1;

  typedef logic [TRNG_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// Power-of-two synchronous word FIFO with flush and a separate level counter.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  word_t                       din,
  output word_t                       dout,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  word_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: storage has no reset; the level counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trng_word_arbiter.sv
// Warm-up discard, word buffering and round-robin hand-off of TRNG words to two consumers.
module trng_word_arbiter
  import trng_pkg::*;
#(
  parameter int WARMUP_WORDS = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int OVF_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [TRNG_WORD_W-1:0]      word_in,
  input  logic                        word_valid,
  input  logic                        req0,
  input  logic                        req1,
  output logic [TRNG_WORD_W-1:0]      rd_data,
  output logic                        gnt0,
  output logic                        gnt1,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        warmup_done,
  output logic [OVF_W-1:0]            overflow_cnt
);

  localparam int WCW = (WARMUP_WORDS > 0) ? $clog2(WARMUP_WORDS + 1) : 1;

  state_t         state;
  state_t         next_state;
  logic [WCW-1:0] discard_cnt;
  logic           last_port;
  logic           win_port;
  logic           run_active;
  logic           pop;
  logic           push;
  logic           drop;
  logic           full;
  logic           empty;
  word_t          head;

  trng_word_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(!enable),
    .din  (word_in),
    .dout (head),
    .level(fifo_level),
    .full (full),
    .empty(empty)
  );

  assign run_active  = (state == RUN) && enable;
  assign warmup_done = (state == RUN);
  assign pop         = run_active && !empty && (req0 || req1);
  assign push        = run_active && word_valid && (!full || pop);
  assign drop        = run_active && word_valid && full && !pop;

  // With both requesting, the port that was not served last goes first.
  always_comb begin
    win_port = 1'(PORT_UART);
    if (req1 && (!req0 || (last_port == 1'(PORT_UART)))) win_port = 1'(PORT_CPU);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = (WARMUP_WORDS == 0) ? RUN : WARMUP;
        WARMUP:  if (word_valid && discard_cnt == WCW'(1)) next_state = RUN;
        RUN:     next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // Reloaded continuously while idle, so every entry into WARMUP starts from a full count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                discard_cnt <= WCW'(WARMUP_WORDS);
    else if (state == IDLE)                 discard_cnt <= WCW'(WARMUP_WORDS);
    else if (state == WARMUP && word_valid) discard_cnt <= discard_cnt - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rd_data      <= '0;
      last_port    <= 1'(PORT_CPU);
      overflow_cnt <= '0;
    end else begin
      gnt0 <= pop && (win_port == 1'(PORT_UART));
      gnt1 <= pop && (win_port == 1'(PORT_CPU));
      if (pop) begin
        rd_data   <= head;
        last_port <= win_port;
      end
      if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_word_arbiter.sv
// Directed and randomized checks of trng_word_arbiter against a queue-based reference model.
module tb_trng_word_arbiter;

  localparam int WARM  = 4;
  localparam int DEPTH = 4;
  localparam int OVFW  = 16;
  localparam int OVF_MAX = (1 << OVFW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] word_in;
  logic        word_valid;
  logic        req0;
  logic        req1;
  logic [31:0] rd_data;
  logic        gnt0;
  logic        gnt1;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        warmup_done;
  logic [OVFW-1:0] overflow_cnt;

  trng_word_arbiter #(
    .WARMUP_WORDS(WARM),
    .FIFO_DEPTH  (DEPTH),
    .OVF_W       (OVFW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .req0        (req0),
    .req1        (req1),
    .rd_data     (rd_data),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .fifo_level  (fifo_level),
    .warmup_done (warmup_done),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered words, operating phase, last served port, drop count.
  logic [31:0] q[$];
  bit          m_run;
  bit          m_warm;
  int          m_skip;
  int          m_last_port;
  int          m_ovf;
  logic [31:0] m_rd;
  bit          m_g0;
  bit          m_g1;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run       = 0;
    m_warm      = 0;
    m_skip      = 0;
    m_last_port = 1;
    m_ovf       = 0;
    m_rd        = '0;
    m_g0        = 0;
    m_g1        = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".gnt0"},  gnt0, m_g0);
    check({tag, ".gnt1"},  gnt1, m_g1);
    check({tag, ".rd"},    rd_data, m_rd);
    check({tag, ".level"}, fifo_level, q.size());
    check({tag, ".wdone"}, warmup_done, m_run);
    check({tag, ".ovf"},   overflow_cnt, m_ovf);
  endtask

  // Drive one cycle of inputs, advance the model, then compare just after the edge.
  task automatic step(input string tag, input bit en, input bit wv, input logic [31:0] w,
                      input bit r0, input bit r1);
    int port;
    enable = en; word_valid = wv; word_in = w; req0 = r0; req1 = r1;
    m_g0 = 0;
    m_g1 = 0;
    if (!en) begin
      q.delete();
      m_run  = 0;
      m_warm = 0;
    end else if (m_run) begin
      if (q.size() > 0 && (r0 || r1)) begin
        if (r0 && r1) port = 1 - m_last_port;
        else          port = r1 ? 1 : 0;
        m_rd = q.pop_front();
        m_g0 = (port == 0);
        m_g1 = (port == 1);
        m_last_port = port;
      end
      if (wv) begin
        if (q.size() < DEPTH) q.push_back(w);
        else if (m_ovf < OVF_MAX) m_ovf++;
      end
    end else if (m_warm) begin
      if (wv) begin
        m_skip--;
        if (m_skip == 0) begin
          m_warm = 0;
          m_run  = 1;
        end
      end
    end else begin
      if (WARM == 0) m_run = 1;
      else begin
        m_warm = 1;
        m_skip = WARM;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  logic [31:0] saved [4];

  initial begin
    rst = 1'b1; enable = 0; word_valid = 0; word_in = '0; req0 = 0; req1 = 0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Warm-up: four discarded words, then a buffered word granted to port 0.
    step("wu.en", 1, 0, 32'h0, 0, 0);
    step("wu.w1", 1, 1, 32'h11111111, 1, 0);
    step("wu.w2", 1, 1, 32'h22222222, 1, 0);
    step("wu.w3", 1, 1, 32'h33333333, 1, 0);
    check("wu.not_done", warmup_done, 1'b0);
    step("wu.w4", 1, 1, 32'h44444444, 1, 0);
    check("wu.done", warmup_done, 1'b1);
    check("wu.no_gnt", gnt0, 1'b0);
    step("wu.a5", 1, 1, 32'hA5A5A5A5, 1, 0);
    check("wu.a5_lvl", fifo_level, 1);
    step("wu.pop", 1, 0, 32'h0, 1, 0);
    check("wu.gnt0", gnt0, 1'b1);
    check("wu.rd", rd_data, 32'hA5A5A5A5);
    step("wu.idle", 1, 0, 32'h0, 0, 0);

    // Serve port 1 once so the pointer favours port 0 for the round-robin run.
    step("rr.pre_push", 1, 1, $urandom, 0, 0);
    step("rr.pre_pop", 1, 0, 32'h0, 0, 1);
    check("rr.pre_gnt1", gnt1, 1'b1);
    for (int i = 1; i <= 4; i++) step("rr.fill", 1, 1, i, 0, 0);
    check("rr.full", fifo_level, 4);
    for (int k = 0; k < 4; k++) begin
      step("rr.both", 1, 0, 32'h0, 1, 1);
      check($sformatf("rr.g0_%0d", k), gnt0, (k % 2 == 0));
      check($sformatf("rr.g1_%0d", k), gnt1, (k % 2 == 1));
      check($sformatf("rr.rd_%0d", k), rd_data, k + 1);
      check($sformatf("rr.lvl_%0d", k), fifo_level, 3 - k);
    end
    step("rr.end", 1, 0, 32'h0, 0, 0);

    // Overflow: six words into a four-deep buffer, then drain in order.
    for (int i = 0; i < 6; i++) step("ov.push", 1, 1, $urandom, 0, 0);
    check("ov.lvl", fifo_level, 4);
    check("ov.cnt", overflow_cnt, 2);
    for (int i = 0; i < 4; i++) step("ov.drain", 1, 0, 32'h0, 1, 0);
    step("ov.end", 1, 0, 32'h0, 0, 0);
    check("ov.empty", fifo_level, 0);

    // Full buffer with a same-cycle push and pop.
    for (int i = 0; i < 4; i++) begin
      saved[i] = $urandom;
      step("fp.fill", 1, 1, saved[i], 0, 0);
    end
    step("fp.both", 1, 1, 32'hDEADBEEF, 0, 1);
    check("fp.gnt1", gnt1, 1'b1);
    check("fp.rd", rd_data, saved[0]);
    check("fp.lvl", fifo_level, 4);
    check("fp.ovf", overflow_cnt, 2);
    for (int i = 0; i < 4; i++) step("fp.drain", 1, 0, 32'h0, 0, 1);
    check("fp.last", rd_data, 32'hDEADBEEF);
    step("fp.end", 1, 0, 32'h0, 0, 0);

    // Disable with three words buffered, then re-enable and repeat warm-up.
    for (int i = 0; i < 3; i++) step("ds.fill", 1, 1, $urandom, 0, 0);
    step("ds.off", 0, 0, 32'h0, 0, 0);
    check("ds.no_gnt", gnt0 | gnt1, 1'b0);
    check("ds.lvl", fifo_level, 0);
    check("ds.wdone", warmup_done, 1'b0);
    check("ds.ovf", overflow_cnt, 2);
    step("ds.on", 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) step("ds.warm", 1, 1, $urandom, 1, 0);
    check("ds.done", warmup_done, 1'b1);
    step("ds.push", 1, 1, 32'hCAFEF00D, 1, 0);
    step("ds.pop", 1, 0, 32'h0, 1, 0);
    check("ds.rd", rd_data, 32'hCAFEF00D);

    // Randomized traffic, including occasional disables.
    for (int i = 0; i < 300; i++)
      step("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    // Async reset while a grant is active.
    step("ar.off", 0, 0, 32'h0, 0, 0);
    step("ar.on", 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) step("ar.warm", 1, 1, $urandom, 0, 0);
    step("ar.push1", 1, 1, $urandom, 0, 0);
    step("ar.push2", 1, 1, $urandom, 0, 0);
    step("ar.pop", 1, 0, 32'h0, 1, 0);
    check("ar.gnt0_pre", gnt0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar.gnt0", gnt0, 1'b0);
    check("ar.lvl", fifo_level, 0);
    check("ar.ovf", overflow_cnt, 0);
    check("ar.wdone", warmup_done, 1'b0);
    model_reset();
    enable = 0; word_valid = 0; req0 = 0; req1 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post.en", 1, 0, 32'h0, 0, 0);
    step("post.w", 1, 1, $urandom, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trng_word_arbiter.md
Name: trng_word_arbiter

Overview:
Sits between the 32-bit TRNG word collector and the two consumers of random words: the UART/STM32 transmit path (port 0) and the CPU/register read path (port 1). After enable it discards a configurable number of warm-up words and buffers accepted words in a small FIFO. It then hands each word to exactly one requester using round-robin arbitration, and counts words dropped on overflow.

Parameters:
WARMUP_WORDS, 4, number of valid collector words discarded after each enable rising edge (0 = no warm-up)
FIFO_DEPTH, 4, word buffer depth; power of two, >=2
OVF_W, 16, width of saturating overflow counter

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
enable  in  1  run request; 0 = idle and flush
word_in  in  32  random word from collector
word_valid  in  1  one-cycle pulse, word_in valid
req0  in  1  port 0 (UART) level request, held until gnt0
req1  in  1  port 1 (CPU) level request, held until gnt1
rd_data  out  32  granted word, valid only while gnt0|gnt1
gnt0  out  1  one-cycle grant to port 0
gnt1  out  1  one-cycle grant to port 1
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered
warmup_done  out  1  high in RUN state
overflow_cnt  out  OVF_W  words dropped because FIFO full, saturating

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; rd_data=0, gnt0=gnt1=0, fifo_level=0, warmup_done=0, overflow_cnt=0; round-robin pointer favours port 0 next.
- States and transitions (all are synchronous except reset):
  - IDLE: FIFO held empty; word_valid ignored. Goes to WARMUP when enable=1. If WARMUP_WORDS=0, goes directly to RUN.
  - WARMUP: each word_valid decrements the discard counter, which is loaded with WARMUP_WORDS on entry. The word arriving when the counter is 1 is discarded, and the next cycle is RUN.
  - RUN: words are pushed and granted. warmup_done=1.
  - Any state with enable=0: next state IDLE; FIFO flushed at that edge; no grant issued in that cycle. overflow_cnt is retained; only rst clears it.
- Push (RUN only): word_valid=1 and (level<FIFO_DEPTH or pop in the same cycle) -> word written at the tail.
  - Full with no pop -> word dropped; overflow_cnt+1, saturating at all-ones.
- Arbitration (RUN only):
  - Evaluated in cycle c on the registered level, so a word pushed in cycle c is grantable at c+1 at the earliest.
  - If level>0 and (req0|req1): the head is popped at the edge ending c. In cycle c+1, rd_data=head, and exactly one of gnt0/gnt1 is 1.
  - Only one requesting: that port wins.
  - Both requesting: the port not granted last wins; pointer updates on every grant.
  - Grant latency is 1 cycle from request seen with non-empty FIFO. A requester whose req stays high during c+1 may be granted again at c+2, giving a throughput of 1 word/cycle total.
- gnt and rd_data are registered. rd_data holds its last value when no grant is active; consumers ignore it then.
- Simultaneous push and pop:
  - When full: both occur and level stays at DEPTH.
  - When level=1: pop the old head, push the new word, level stays 1.
- Pointers wrap modulo FIFO_DEPTH. Level is a separate counter of width $clog2(FIFO_DEPTH)+1 and never exceeds DEPTH.
- A word is delivered exactly once, and no word is duplicated or reordered (FIFO order).

Decomposition:
- Shared package trng_pkg:
  - TRNG_WORD_W=32.
  - State encoding: IDLE=2'd0, WARMUP=2'd1, RUN=2'd2.
  - Port index constants PORT_UART=0, PORT_CPU=1.
- Sub-module trng_word_fifo:
  - Synchronous FIFO with push, pop, flush, level, full, empty; parameter FIFO_DEPTH.
  - Arbiter, warm-up FSM and overflow counter stay in the top module.

Test Plan:
- Reset and warm-up: rst pulse; enable=1; 4 words 0x11111111..0x44444444 then 0xA5A5A5A5, req0 held. Required: the first 4 words are never granted; warmup_done rises the cycle after the 4th word; gnt0 with rd_data=0xA5A5A5A5 one cycle after it is buffered.
- Round-robin: FIFO preloaded with 0x1,0x2,0x3,0x4; req0=req1=1 continuously. Required: grants alternate gnt0(0x1), gnt1(0x2), gnt0(0x3), gnt1(0x4) on consecutive cycles; level goes 4->0.
- Overflow: no requests; 6 word_valid pulses in RUN. Required: level=4, overflow_cnt=2; a subsequent drain yields only the first 4 words, in order.
- Full with simultaneous push/pop: level=4, req1=1 and word_valid=1 with 0xDEADBEEF in the same cycle. Required: gnt1 with the old head, level stays 4, overflow_cnt unchanged, 0xDEADBEEF delivered last.
- Disable mid-operation: level=3, drop enable for 1 cycle, then re-enable. Required: no grant in the disable cycle; level=0 next cycle; state passes through IDLE; warm-up repeats with 4 discarded words; overflow_cnt is retained.
- Async reset mid-grant: assert rst between clock edges while gnt0=1. Required: gnt0, level, overflow_cnt and warmup_done go to 0 immediately, without waiting for a clock edge.
